controller_token: RTL and testbench
===================================

// Module: controller_token
// PURPOSE
// - Pipeline-stage controller for a timing-resilient (error-detecting) datapath.
// - Handshakes four-phase with the left and right stages on two channels each:
//   a data channel (req/ack) and an error channel (Ereq/Eack).
// - Pulses the stage latch clock, then raises sample to the error detectors.
// - Error-free tokens go out immediately; tokens with an error go out after a recovery delay.
// - "Token" variant: after reset the stage holds one valid token and offers it to the right.
// PARAMETERS
// - SAMPLE_DLY   default 1  cycles from the lclk pulse to the sample rising edge
// - ERR_DLY      default 2  extra cycles sample stays high when an error is flagged
// - SYNC_STAGES  default 2  flop depth of each input synchroniser (>=2)
// - TOKEN_INIT   default 1  1 = stage holds a token at reset and issues Rreq first
// PORTS
// - clk    in  1  single system clock; all state on rising edge
// - rst    in  1  asynchronous, active-low reset (0 = reset)
// - Lreq   in  1  left data request
// - Lack   out 1  left data acknowledge
// - Rreq   out 1  right data request
// - Rack   in  1  right data acknowledge
// - LEreq  out 1  error-channel request to left (capture resolved)
// - LEack  in  1  error-channel acknowledge from left
// - REreq  in  1  error-channel request from right
// - REack  out 1  error-channel acknowledge to right
// - lclk   out 1  stage latch enable; one-cycle pulse per capture
// - sample out 1  sample strobe to the error-detecting latches
// - Err0   in  1  dual-rail "no error" rail
// - Err1   in  1  dual-rail "error" rail
// BEHAVIOUR
// - Reset: all outputs 0 and both FSMs idle, with these exceptions:
//   - The R-port send-pending flag is TOKEN_INIT.
//   - Rreq rises 1 cycle after rst deasserts when TOKEN_INIT=1.
// - Input synchronisers: every input passes SYNC_STAGES flops.
//   - All latencies below count from the synchronised value.
//   - All outputs are registered.
// - Main FSM:
//   - IDLE: proceed when Lreq=1 && R-port idle && LEack=0. Next: CAPTURE.
//   - CAPTURE (1 cycle): lclk=1, Lack<=1. Next: DELAY.
//   - DELAY: wait SAMPLE_DLY cycles. Next: SAMPLE.
//   - SAMPLE: sample=1; wait for Err0|Err1.
//     - Err0 only: go to RESOLVE.
//     - Err1=1: go to ERRWAIT. Both rails high is treated as an error.
//   - ERRWAIT: sample held 1 for ERR_DLY cycles. Next: RESOLVE.
//   - RESOLVE (1 cycle): sample<=0, send pulse to R port, LEreq<=1. Next: RTZ.
//   - RTZ, in order:
//     - Wait Err0=Err1=0 and LEack=1, then LEreq<=0.
//     - Wait Lreq=0, then Lack<=0.
//     - Wait LEack=0, then go to IDLE.
// - R port (four-phase with error channel):
//   - send pulse or token pending -> Rreq<=1.
//   - REreq=1 -> REack<=1.
//   - Rack=1 -> Rreq<=0.
//   - REreq=0 -> REack<=0.
//   - Rack=0 -> idle.
//   - REack never rises before Rreq=1. A send arriving while busy is held pending, never lost.
// - Hold conditions:
//   - lclk never pulses while the R port is busy, so the latch is not overwritten before Rack returns.
//   - Lack never falls before Lreq falls.
//   - sample never rises while Err0|Err1 is still high from the previous token; DELAY extends until both are low.
// - Simultaneous Lreq and REreq: both are served the same cycle; the FSMs are independent.
// - Reset mid-operation: immediate return to reset values, and the token is re-issued per TOKEN_INIT.
//   The environment must also reset.
// STRUCTURE
// - Package ctrl_token_pkg:
//   - main FSM state enum (IDLE, CAPTURE, DELAY, SAMPLE, ERRWAIT, RESOLVE, RTZ)
//   - R-port state enum (R_IDLE, R_REQ, R_ACK, R_RTZ)
//   - parameter defaults
// - Sub-module ctrl_r_port: right four-phase data plus error-channel handshake, with the send-pending flag.
// - Synchronisers: a generate loop inside controller_token.
// TESTING
// - Reset/token:
//   - rst=0 -> all outputs 0.
//   - Release rst -> Rreq=1 next cycle.
//   - REreq=1 -> REack=1; Rack=1 -> Rreq=0.
// - No error:
//   - Stimulus: Lreq=1, R idle.
//   - lclk exactly 1 cycle high, then Lack=1.
//   - sample=1 SAMPLE_DLY(1) cycles later.
//   - Err0=1 -> sample=0, Rreq=1, LEreq=1 next cycle.
// - Error:
//   - Stimulus: Err1=1 in SAMPLE.
//   - sample stays high ERR_DLY(2) extra cycles, then Rreq=1.
//   - Exactly one lclk pulse per token.
// - Backpressure:
//   - Stimulus: Rack delayed 50 cycles for the 4th token.
//   - Next lclk/Lack only after Rack falls; no token is lost or duplicated.
// - Mixed run:
//   - Pattern: 2 clean tokens, then 2 error tokens, repeated over 10 tokens with 20-cycle environment handshake delays.
//   - Rreq count equals lclk count plus TOKEN_INIT.
// - Reset mid-SAMPLE:
//   - Assert rst low while sample=1 -> outputs 0 asynchronously.
//   - On release, token reissued.

Source files
------------

// File: rtl/ctrl_token_pkg.sv
// Shared state encodings and parameter defaults for the token-holding stage controller.
package ctrl_token_pkg;

  localparam int SAMPLE_DLY_DEF  = 1;
  localparam int ERR_DLY_DEF     = 2;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TOKEN_INIT_DEF  = 1;
  localparam int CNT_W           = 8;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DELAY,
    SAMPLE,
    ERRWAIT,
    RESOLVE,
    RTZ
  } main_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_ACK,
    R_RTZ
  } r_state_t;

endpackage

// File: rtl/ctrl_r_port.sv
// Right-side four-phase data + error-channel handshake; Rreq rises the edge after a send (or reset token).
// A send arriving while busy is parked in the pending flag and issued once the port returns to idle.
module ctrl_r_port import ctrl_token_pkg::*; #(
  parameter int TOKEN_INIT = TOKEN_INIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic send,
  input  logic rack,
  input  logic rereq,
  output logic rreq,
  output logic reack,
  output logic idle
);

  r_state_t state, state_nxt;
  logic     pend, pend_nxt;
  logic     rreq_nxt, reack_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= R_IDLE;
      pend  <= (TOKEN_INIT != 0);
      rreq  <= 1'b0;
      reack <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      rreq  <= rreq_nxt;
      reack <= reack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend | send;
    rreq_nxt  = rreq;
    reack_nxt = reack;

    // Error-channel ack may only rise once Rreq has been offered for this token.
    if (!rereq)
      reack_nxt = 1'b0;
    else if (state == R_REQ || state == R_ACK)
      reack_nxt = 1'b1;

    case (state)
      R_IDLE: if (pend || send) begin
        rreq_nxt  = 1'b1;
        pend_nxt  = 1'b0;
        state_nxt = R_REQ;
      end
      R_REQ: if (rack) begin
        rreq_nxt  = 1'b0;
        state_nxt = R_ACK;
      end
      R_ACK: if (!rack) state_nxt = R_RTZ;
      R_RTZ: if (!rereq && !reack) state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  assign idle = (state == R_IDLE) && !pend;

endmodule

// File: rtl/controller_token.sv
// Error-detecting pipeline stage controller: capture, sample, then forward clean tokens at once and
// errored tokens after ERR_DLY; capture is held off while the right port is busy or the left has not returned to zero.
module controller_token import ctrl_token_pkg::*; #(
  parameter int SAMPLE_DLY  = SAMPLE_DLY_DEF,
  parameter int ERR_DLY     = ERR_DLY_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TOKEN_INIT  = TOKEN_INIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic Lreq,
  output logic Lack,
  output logic Rreq,
  input  logic Rack,
  output logic LEreq,
  input  logic LEack,
  input  logic REreq,
  output logic REack,
  output logic lclk,
  output logic sample,
  input  logic Err0,
  input  logic Err1
);

  localparam int NIN = 6;
  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(SAMPLE_DLY - 1);
  localparam logic [CNT_W-1:0] ERR_LAST = CNT_W'(ERR_DLY - 1);

  logic [NIN-1:0] in_raw, in_sync;
  logic lreq_s, rack_s, leack_s, rereq_s, err0_s, err1_s;

  assign in_raw = {Lreq, Rack, LEack, REreq, Err0, Err1};

  for (genvar i = 0; i < NIN; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) q <= '0;
      else      q <= {q[SYNC_STAGES-2:0], in_raw[i]};
    end
    assign in_sync[i] = q[SYNC_STAGES-1];
  end

  assign {lreq_s, rack_s, leack_s, rereq_s, err0_s, err1_s} = in_sync;

  main_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lclk_nxt, lack_nxt, sample_nxt, lereq_nxt;
  logic             send, resolve, r_idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      lclk   <= 1'b0;
      Lack   <= 1'b0;
      sample <= 1'b0;
      LEreq  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      lclk   <= lclk_nxt;
      Lack   <= lack_nxt;
      sample <= sample_nxt;
      LEreq  <= lereq_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    lclk_nxt   = 1'b0;
    lack_nxt   = Lack;
    sample_nxt = sample;
    lereq_nxt  = LEreq;
    send       = 1'b0;
    resolve    = 1'b0;

    case (state)
      IDLE: if (lreq_s && r_idle && !leack_s) begin
        state_nxt = CAPTURE;
        lclk_nxt  = 1'b1;
      end
      CAPTURE: begin
        lack_nxt  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = DELAY;
      end
      // Stay here past the nominal delay until the detectors have cleared from the last token.
      DELAY: if (cnt < SMP_LAST) begin
        cnt_nxt = cnt + CNT_W'(1);
      end else if (!err0_s && !err1_s) begin
        state_nxt  = SAMPLE;
        sample_nxt = 1'b1;
      end
      SAMPLE: if (err1_s) begin
        state_nxt = ERRWAIT;
        cnt_nxt   = '0;
      end else if (err0_s) begin
        resolve = 1'b1;
      end
      ERRWAIT: if (cnt < ERR_LAST) cnt_nxt = cnt + CNT_W'(1);
               else                resolve = 1'b1;
      RESOLVE: state_nxt = RTZ;
      // Return-to-zero progress is tracked by which left outputs are still high.
      RTZ: if (LEreq) begin
        if (!err0_s && !err1_s && leack_s) lereq_nxt = 1'b0;
      end else if (Lack) begin
        if (!lreq_s) lack_nxt = 1'b0;
      end else if (!leack_s) begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (resolve) begin
      state_nxt  = RESOLVE;
      sample_nxt = 1'b0;
      lereq_nxt  = 1'b1;
      send       = 1'b1;
    end
  end

  ctrl_r_port #(
    .TOKEN_INIT(TOKEN_INIT)
  ) u_r_port (
    .clk   (clk),
    .rst   (rst),
    .send  (send),
    .rack  (rack_s),
    .rereq (rereq_s),
    .rreq  (Rreq),
    .reack (REack),
    .idle  (r_idle)
  );

endmodule

// File: tb/tb_controller_token.sv
// Randomised bench for controller_token: models both neighbours and the error detectors,
// and checks handshake timing and token accounting against expectations derived from the stage rules.
module tb_controller_token;

  localparam int SAMPLE_DLY  = 1;
  localparam int ERR_DLY     = 2;
  localparam int SYNC_STAGES = 2;
  localparam int TOKEN_INIT  = 1;
  localparam int NTOK        = 10;
  localparam int BUDGET      = 500;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic Lreq = 1'b0, Rack = 1'b0, LEack = 1'b0, REreq = 1'b0, Err0 = 1'b0, Err1 = 1'b0;
  logic Lack, Rreq, LEreq, REack, lclk, sample;

  int total = 0;
  int bad   = 0;

  bit env_run   = 1'b0;
  bit mon_en    = 1'b0;
  bit left_done = 1'b0;
  int rack_hs   = 0;
  bit tok_err [NTOK];

  int   cyc = 0, lclk_t = 0, smp_t = 0, smp_idx = 0;
  int   lclk_cnt = 0, rreq_cnt = 0, lack_cnt = 0;
  logic p_lclk = 1'b0, p_lack = 1'b0, p_smp = 1'b0, p_rreq = 1'b0, p_reack = 1'b0;

  always #5 clk = ~clk;

  controller_token #(
    .SAMPLE_DLY  (SAMPLE_DLY),
    .ERR_DLY     (ERR_DLY),
    .SYNC_STAGES (SYNC_STAGES),
    .TOKEN_INIT  (TOKEN_INIT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .Lreq   (Lreq),
    .Lack   (Lack),
    .Rreq   (Rreq),
    .Rack   (Rack),
    .LEreq  (LEreq),
    .LEack  (LEack),
    .REreq  (REreq),
    .REack  (REack),
    .lclk   (lclk),
    .sample (sample),
    .Err0   (Err0),
    .Err1   (Err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic out_sig(input int w);
    case (w)
      0:       return Lack;
      1:       return Rreq;
      2:       return REack;
      3:       return LEreq;
      4:       return sample;
      default: return lclk;
    endcase
  endfunction

  // Bounded wait for a DUT response; the final value is always checked.
  task automatic wait_out(input int w, input logic val, input string tag);
    int n = 0;
    while (out_sig(w) !== val && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, out_sig(w)}, {31'd0, val});
  endtask

  task automatic wait_env(input int w, input logic val);
    while (out_sig(w) !== val && env_run) @(negedge clk);
  endtask

  task automatic left_env();
    for (int i = 0; i < NTOK; i++) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      Lreq = 1'b1;
      wait_out(0, 1'b1, "lack_rise");
      repeat ($urandom_range(1, 20)) @(negedge clk);
      Lreq = 1'b0;
      wait_out(0, 1'b0, "lack_fall");
    end
    left_done = 1'b1;
  endtask

  task automatic leack_env();
    while (env_run) begin
      wait_env(3, 1'b1);
      if (!env_run) break;
      repeat ($urandom_range(0, 20)) @(negedge clk);
      LEack = 1'b1;
      wait_out(3, 1'b0, "lereq_fall");
      repeat ($urandom_range(0, 20)) @(negedge clk);
      LEack = 1'b0;
    end
  endtask

  task automatic right_env();
    while (env_run) begin
      wait_env(1, 1'b1);
      if (!env_run) break;
      repeat ($urandom_range(0, 20)) @(negedge clk);
      REreq = 1'b1;
      wait_out(2, 1'b1, "reack_rise");
      if (rack_hs == 4) repeat (50) @(negedge clk);
      else              repeat ($urandom_range(0, 20)) @(negedge clk);
      Rack = 1'b1;
      wait_out(1, 1'b0, "rreq_fall");
      repeat ($urandom_range(0, 20)) @(negedge clk);
      Rack  = 1'b0;
      REreq = 1'b0;
      wait_out(2, 1'b0, "reack_fall");
      rack_hs++;
    end
  endtask

  // Detectors answer on the first falling edge that sees sample high.
  task automatic det_env();
    int d = 0;
    while (env_run) begin
      wait_env(4, 1'b1);
      if (!env_run) break;
      if (d < NTOK && tok_err[d]) begin
        Err1 = 1'b1;
        Err0 = 1'($urandom_range(0, 1));
      end else begin
        Err0 = 1'b1;
      end
      wait_out(4, 1'b0, "sample_fall");
      Err0 = 1'b0;
      Err1 = 1'b0;
      d++;
    end
  endtask

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    p_lclk  <= lclk;
    p_lack  <= Lack;
    p_smp   <= sample;
    p_rreq  <= Rreq;
    p_reack <= REack;
    if (mon_en) begin
      if (lclk && !p_lclk) begin
        lclk_cnt <= lclk_cnt + 1;
        lclk_t   <= cyc;
        chk("lclk_while_r_busy", {29'd0, Rreq, REack, Rack}, 32'd0);
      end
      if (!lclk && p_lclk) chk("lclk_width", cyc - lclk_t, 1);
      if (Lack && !p_lack) begin
        lack_cnt <= lack_cnt + 1;
        chk("lack_after_lclk", cyc - lclk_t, 1);
      end
      if (!Lack && p_lack) chk("lack_fall_before_lreq", {31'd0, Lreq}, 32'd0);
      if (sample && !p_smp) begin
        smp_t <= cyc;
        chk("sample_delay", cyc - lclk_t, 1 + SAMPLE_DLY);
      end
      if (!sample && p_smp) begin
        chk("sample_len", cyc - smp_t,
            SYNC_STAGES + 1 + ((smp_idx < NTOK && tok_err[smp_idx]) ? ERR_DLY : 0));
        chk("resolve_rreq", {30'd0, Rreq, p_rreq}, 32'd2);
        chk("resolve_lereq", {31'd0, LEreq}, 32'd1);
        smp_idx <= smp_idx + 1;
      end
      if (Rreq && !p_rreq) rreq_cnt <= rreq_cnt + 1;
      if (REack && !p_reack) chk("reack_needs_rreq", {31'd0, Rreq}, 32'd1);
    end
  end

  initial begin
    int n;
    for (int i = 0; i < NTOK; i++) tok_err[i] = ((i / 2) % 2) == 1;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, Lack, Rreq, REack, LEreq, lclk, sample}, 32'd0);
    mon_en  = 1'b1;
    env_run = 1'b1;
    rst     = 1'b1;
    #1 chk("rreq_before_edge", {31'd0, Rreq}, 32'd0);
    @(posedge clk);
    #1 chk("token_rreq_after_release", {31'd0, Rreq}, 32'd1);

    fork
      left_env();
      right_env();
      leack_env();
      det_env();
    join_none

    n = 0;
    while ((!left_done || rack_hs < NTOK + TOKEN_INIT) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("tokens_delivered", rack_hs, NTOK + TOKEN_INIT);
    chk("lclk_count", lclk_cnt, NTOK);
    chk("lack_count", lack_cnt, NTOK);
    chk("samples_seen", smp_idx, NTOK);
    chk("rreq_eq_lclk_plus_token", rreq_cnt, lclk_cnt + TOKEN_INIT);

    repeat (40) @(negedge clk);
    env_run = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    Lreq = 1'b0; Rack = 1'b0; LEack = 1'b0; REreq = 1'b0; Err0 = 1'b0; Err1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("quiet_outputs", {26'd0, Lack, Rreq, REack, LEreq, lclk, sample}, 32'd0);

    Lreq = 1'b1;
    wait_out(4, 1'b1, "sample_before_reset");
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", {26'd0, Lack, Rreq, REack, LEreq, lclk, sample}, 32'd0);
    Lreq = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_in_reset", {26'd0, Lack, Rreq, REack, LEreq, lclk, sample}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("token_reissued", {31'd0, Rreq}, 32'd1);
    chk("no_lack_after_reset", {31'd0, Lack}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
